// File: rtl/pu_accum_tree.sv
// -----------------------------------------------------------------------------
// pu_accum_tree
//
// Pipelined signed reduction of IC_NUM input-channel partial sums followed by
// a multi-cycle group accumulator. One result is emitted per input-channel
// group; the group is delimited by first_i / last_i on valid beats.
//
// Pipeline (IC_NUM = 8 shown):
//   edge n     : leaf registers capture the sign-extended channels
//   edge n+1.. : one register per adder-tree level (log2(IC_NUM) levels)
//   edge n+L   : accumulator / output registers, L = log2(IC_NUM) + 1
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   vld_i        input beat valid
//   first_i      beat opens a new group (qualified by vld_i)
//   last_i       beat closes the group  (qualified by vld_i)
//   pe_rf_i      packed signed partial sums, channel k at [k*PE_OUTPUT_WD +: PE_OUTPUT_WD]
//   accum_o      signed group result, held between strobes
//   accum_vld_o  one-cycle strobe marking a new accum_o
//   ovf_o        accumulation overflowed within the reported group
//
// Configuration macro
//   PU_ACCUM_SAT_EN  defined   : accumulator saturates on overflow
//                    undefined : accumulator wraps modulo 2^ACCUM_WD
//   ovf_o reports the overflow event in both builds.
// -----------------------------------------------------------------------------
module pu_accum_tree #(
  parameter int IC_NUM       = 8,
  parameter int PE_OUTPUT_WD = 18,
  parameter int ACCUM_WD     = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_i,
  input  logic                           first_i,
  input  logic                           last_i,
  input  logic [IC_NUM*PE_OUTPUT_WD-1:0] pe_rf_i,
  output logic [ACCUM_WD-1:0]            accum_o,
  output logic                           accum_vld_o,
  output logic                           ovf_o
);

  localparam int LEVELS = $clog2(IC_NUM);
  // Heap-ordered tree: node 0 is the root, node i has children 2i+1 / 2i+2,
  // leaves occupy IC_NUM-1 .. 2*IC_NUM-2. Every node is a register, so a
  // node at depth d is one cycle behind its children and the whole tree is
  // naturally pipelined one level per cycle.
  localparam int NODES  = 2 * IC_NUM - 1;
  // Flag pipeline covers the leaf stage plus every tree level.
  localparam int DEPTH  = LEVELS + 1;

  localparam logic [ACCUM_WD-1:0] ACC_MAX = {1'b0, {(ACCUM_WD-1){1'b1}}};
  localparam logic [ACCUM_WD-1:0] ACC_MIN = {1'b1, {(ACCUM_WD-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Adder tree
  // ---------------------------------------------------------------------------
  logic signed [ACCUM_WD-1:0] node_q [NODES];
  logic signed [ACCUM_WD-1:0] node_d [NODES];

  generate
    for (genvar gi = 0; gi < IC_NUM; gi++) begin : g_leaf
      assign node_d[IC_NUM-1+gi] =
        ACCUM_WD'($signed(pe_rf_i[gi*PE_OUTPUT_WD +: PE_OUTPUT_WD]));
    end
    // ACCUM_WD >= PE_OUTPUT_WD + log2(IC_NUM), so no level sum can overflow.
    for (genvar gi = 0; gi < IC_NUM - 1; gi++) begin : g_node
      assign node_d[gi] = node_q[2*gi+1] + node_q[2*gi+2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) node_q[i] <= '0;
    end else begin
      for (int i = 0; i < NODES; i++) node_q[i] <= node_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Flag pipeline, aligned with the tree so that index DEPTH-1 travels with
  // the root node value.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] vld_q,   vld_d;
  logic [DEPTH-1:0] first_q, first_d;
  logic [DEPTH-1:0] last_q,  last_d;

  always_comb begin
    vld_d   = {vld_q[DEPTH-2:0],   vld_i};
    first_d = {first_q[DEPTH-2:0], first_i};
    last_d  = {last_q[DEPTH-2:0],  last_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Group accumulator and output registers
  // ---------------------------------------------------------------------------
  logic [ACCUM_WD-1:0] acc_q,       acc_d;
  logic                ovf_flag_q,  ovf_flag_d;
  logic [ACCUM_WD-1:0] accum_q,     accum_d;
  logic                accum_vld_q, accum_vld_d;
  logic                ovf_q,       ovf_d;

  logic [ACCUM_WD-1:0] tree_sum;
  logic                beat_vld;
  logic                beat_first;
  logic                beat_last;
  logic [ACCUM_WD:0]   sum_ext;
  logic                ovf_now;

  assign tree_sum   = node_q[0];
  assign beat_vld   = vld_q[DEPTH-1];
  assign beat_first = first_q[DEPTH-1];
  assign beat_last  = last_q[DEPTH-1];

  always_comb begin
    acc_d       = acc_q;
    ovf_flag_d  = ovf_flag_q;
    accum_d     = accum_q;
    ovf_d       = ovf_q;
    accum_vld_d = 1'b0;

    // One extra bit holds the true sum; overflow shows up as the top two
    // bits disagreeing, and the top bit is the sign of the true sum.
    sum_ext = {acc_q[ACCUM_WD-1], acc_q} + {tree_sum[ACCUM_WD-1], tree_sum};
    ovf_now = sum_ext[ACCUM_WD] ^ sum_ext[ACCUM_WD-1];

    if (beat_vld) begin
      if (beat_first) begin
        // A first beat always restarts, discarding any open partial group.
        acc_d      = tree_sum;
        ovf_flag_d = 1'b0;
      end else begin
        ovf_flag_d = ovf_flag_q | ovf_now;
`ifdef PU_ACCUM_SAT_EN
        if (ovf_now) begin
          acc_d = sum_ext[ACCUM_WD] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_d = sum_ext[ACCUM_WD-1:0];
        end
`else
        acc_d = sum_ext[ACCUM_WD-1:0];
`endif
      end

      if (beat_last) begin
        accum_d     = acc_d;
        ovf_d       = ovf_flag_d;
        accum_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      ovf_flag_q  <= 1'b0;
      accum_q     <= '0;
      accum_vld_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_flag_q  <= ovf_flag_d;
      accum_q     <= accum_d;
      accum_vld_q <= accum_vld_d;
      ovf_q       <= ovf_d;
    end
  end

  assign accum_o     = accum_q;
  assign accum_vld_o = accum_vld_q;
  assign ovf_o       = ovf_q;

  // Saturation bounds are only referenced by the saturating build.
  logic unused_bounds;
  assign unused_bounds = ^{ACC_MAX, ACC_MIN};

endmodule

// File: tb/tb_pu_accum_tree.sv
// -----------------------------------------------------------------------------
// tb_pu_accum_tree
//
// Self-checking bench for pu_accum_tree (IC_NUM=8, PE_OUTPUT_WD=18,
// ACCUM_WD=24). A behavioural model works on whole beats with integer
// arithmetic and schedules each expected strobe at (sampling edge + 4).
// A compare process checks the outputs on every falling edge: strobe
// presence, strobed value/flag, and that values hold between strobes.
// Directed groups additionally pin the model and the DUT to literal values.
// Build with +define+PU_ACCUM_SAT_EN to exercise the saturating variant.
// -----------------------------------------------------------------------------
module tb_pu_accum_tree;

  localparam int IC_NUM       = 8;
  localparam int PE_OUTPUT_WD = 18;
  localparam int ACCUM_WD     = 24;
  localparam int LAT          = 4;
  localparam int NSLOT        = 8192;

  localparam longint ACC_MAX  = (64'sd1 <<< (ACCUM_WD-1)) - 1;
  localparam longint ACC_MIN  = -(64'sd1 <<< (ACCUM_WD-1));

  logic                           clk;
  logic                           rst;
  logic                           vld_i;
  logic                           first_i;
  logic                           last_i;
  logic [IC_NUM*PE_OUTPUT_WD-1:0] pe_rf_i;
  logic signed [ACCUM_WD-1:0]     accum_o;
  logic                           accum_vld_o;
  logic                           ovf_o;

  pu_accum_tree #(
    .IC_NUM       (IC_NUM),
    .PE_OUTPUT_WD (PE_OUTPUT_WD),
    .ACCUM_WD     (ACCUM_WD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_i       (vld_i),
    .first_i     (first_i),
    .last_i      (last_i),
    .pe_rf_i     (pe_rf_i),
    .accum_o     (accum_o),
    .accum_vld_o (accum_vld_o),
    .ovf_o       (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;
  int  beat_vals [IC_NUM];

  bit  exp_vld [NSLOT];
  int  exp_val [NSLOT];
  bit  exp_ovf [NSLOT];

  longint macc = 0;
  bit     movf = 1'b0;
  int     mlast_val = 0;
  bit     mlast_ovf = 1'b0;

  int  hold_val = 0;
  bit  hold_ovf = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic longint wrap(input longint t);
    longint r;
    r = t & ((64'sd1 <<< ACCUM_WD) - 1);
    if (r > ACC_MAX) r = r - (64'sd1 <<< ACCUM_WD);
    return r;
  endfunction

  // One beat: present inputs, let the rising edge sample them, then advance
  // the model with the beat that was just sampled.
  task automatic step(input bit v, input bit f, input bit l);
    longint s;
    longint t;
    vld_i   = v;
    first_i = f;
    last_i  = l;
    for (int k = 0; k < IC_NUM; k++)
      pe_rf_i[k*PE_OUTPUT_WD +: PE_OUTPUT_WD] = beat_vals[k][PE_OUTPUT_WD-1:0];
    @(posedge clk);
    edge_n++;
    if (v && !rst) begin
      s = 0;
      for (int k = 0; k < IC_NUM; k++) s += beat_vals[k];
      if (f) begin
        macc = s;
        movf = 1'b0;
      end else begin
        t = macc + s;
        if (t > ACC_MAX || t < ACC_MIN) begin
          movf = 1'b1;
`ifdef PU_ACCUM_SAT_EN
          macc = (t > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
          macc = wrap(t);
`endif
        end else begin
          macc = t;
        end
      end
      if (l) begin
        exp_vld[edge_n+LAT] = 1'b1;
        exp_val[edge_n+LAT] = int'(macc);
        exp_ovf[edge_n+LAT] = movf;
        mlast_val = int'(macc);
        mlast_ovf = movf;
      end
    end
    #1;
  endtask

  task automatic set_all(input int val);
    for (int k = 0; k < IC_NUM; k++) beat_vals[k] = val;
  endtask

  task automatic beat(input bit v, input bit f, input bit l, input int val);
    set_all(val);
    step(v, f, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Checks a strobe at the falling edge following the current cycle against
  // literal values, and checks that the model agrees with the same literals.
  task automatic check_lit(input string name, input int val, input bit ovf);
    @(negedge clk);
    chk({name, "_vld"}, accum_vld_o, 1);
    chk({name, "_val"}, int'(accum_o), val);
    chk({name, "_ovf"}, ovf_o, ovf);
    chk({name, "_model_val"}, mlast_val, val);
    chk({name, "_model_ovf"}, mlast_ovf, ovf);
    $display("group %s: accum_o=%0d ovf_o=%0d", name, int'(accum_o), ovf_o);
  endtask

  // Per-cycle compare against the model schedule.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_val = 0;
        hold_ovf = 1'b0;
        chk("rst_vld", accum_vld_o, 0);
        chk("rst_val", int'(accum_o), 0);
        chk("rst_ovf", ovf_o, 0);
      end else if (exp_vld[edge_n]) begin
        chk("strobe_vld", accum_vld_o, 1);
        chk("strobe_val", int'(accum_o), exp_val[edge_n]);
        chk("strobe_ovf", ovf_o, exp_ovf[edge_n]);
        hold_val = exp_val[edge_n];
        hold_ovf = exp_ovf[edge_n];
      end else begin
        chk("idle_vld", accum_vld_o, 0);
        chk("hold_val", int'(accum_o), hold_val);
        chk("hold_ovf", ovf_o, hold_ovf);
      end
    end
  end

  task automatic rand_beat_vals(input int mode);
    for (int k = 0; k < IC_NUM; k++) begin
      case (mode)
        0:       beat_vals[k] = int'($urandom_range(0, 262143)) - 131072;
        1:       beat_vals[k] = int'($urandom_range(120000, 131071));
        default: beat_vals[k] = -int'($urandom_range(120000, 131072));
      endcase
    end
  endtask

  initial begin
    int expected_sat;
    int len;
    int mode;
    bit abandon;
    bit f;
    bit l;

    rst     = 1'b1;
    vld_i   = 1'b0;
    first_i = 1'b0;
    last_i  = 1'b0;
    pe_rf_i = '0;
    set_all(0);
    for (int i = 0; i < NSLOT; i++) begin
      exp_vld[i] = 1'b0;
      exp_val[i] = 0;
      exp_ovf[i] = 1'b0;
    end

    #1;
    chk("reset_val", int'(accum_o), 0);
    chk("reset_vld", accum_vld_o, 0);
    chk("reset_ovf", ovf_o, 0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single-beat group at positive full scale; strobe exactly 4 edges later.
    beat(1, 1, 1, 131071);
    idle(LAT);
    check_lit("max_single", 1048568, 1'b0);

    beat(1, 1, 1, -131072);
    idle(LAT);
    check_lit("min_single", -1048576, 1'b0);

    beat_vals = '{1, -2, 3, -4, 5, -6, 7, -8};
    step(1, 1, 1);
    idle(LAT);
    check_lit("mixed_single", -4, 1'b0);

    // Three beats with two bubbles carrying noise on the flags.
    beat(1, 1, 0, 1000);
    beat(0, 1, 1, 777);
    beat(1, 0, 0, 1000);
    beat(0, 0, 1, 555);
    beat(1, 0, 1, 1000);
    idle(LAT);
    check_lit("three_beat", 24000, 1'b0);

    // Nine full-scale beats overflow on the ninth.
    beat(1, 1, 0, 131071);
    for (int i = 0; i < 7; i++) beat(1, 0, 0, 131071);
    beat(1, 0, 1, 131071);
    idle(LAT);
`ifdef PU_ACCUM_SAT_EN
    expected_sat = 8388607;
`else
    expected_sat = -7340104;
`endif
    check_lit("nine_beat_ovf", expected_sat, 1'b1);

    // Restart: an open group is abandoned by a new first+last beat.
    beat(1, 1, 0, 5);
    beat(1, 0, 0, 5);
    beat(1, 1, 1, 2);
    idle(LAT);
    check_lit("restart", 16, 1'b0);

    // Reset while a 3-beat group is in flight.
    beat(1, 1, 0, 7);
    beat(1, 0, 0, 7);
    beat(1, 0, 1, 7);
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_val", int'(accum_o), 0);
    chk("async_rst_vld", accum_vld_o, 0);
    chk("async_rst_ovf", ovf_o, 0);
    for (int i = edge_n + 1; i <= edge_n + 2 * LAT; i++) exp_vld[i] = 1'b0;
    macc = 0;
    movf = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(2);
    beat(1, 1, 1, 3);
    idle(LAT);
    check_lit("after_reset", 24, 1'b0);

    // Back-to-back single-beat groups: a strobe every cycle.
    for (int i = 0; i < 8; i++) begin
      rand_beat_vals(0);
      step(1, 1, 1);
    end
    idle(LAT);

    // Randomized groups with bubbles, restarts and overflow-prone values.
    for (int g = 0; g < 250; g++) begin
      len     = int'($urandom_range(1, 10));
      mode    = int'($urandom_range(0, 3));
      abandon = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          rand_beat_vals(0);
          step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_beat_vals(mode > 2 ? 0 : mode);
        f = (b == 0);
        l = (b == len - 1) && !abandon;
        step(1'b1, f, l);
      end
    end
    idle(LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
